// File: rtl/pulse_tdc_pkg.sv
// Shared constants, types and helpers for the pulse-width TDC.
package pulse_tdc_pkg;

  localparam int         WIDTH_BITS = 12;
  localparam logic [7:0] VERSION    = 8'd1;

  // Register offsets inside the bus window
  localparam logic [3:0] REG_RESET = 4'd0;
  localparam logic [3:0] REG_CONF  = 4'd1;
  localparam logic [3:0] REG_EVT   = 4'd2;
  localparam logic [3:0] REG_LOST  = 4'd6;
  localparam logic [3:0] REG_TS    = 4'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } tdc_state_e;

  typedef struct packed {
    logic [3:0]            id;
    logic [15:0]           tag;
    logic [WIDTH_BITS-1:0] width;
  } tdc_word_t;

  function automatic logic [WIDTH_BITS-1:0] sat_inc(input logic [WIDTH_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pulse_tdc_if.sv
// Readout handshake between the TDC FIFO and the round-robin arbiter.
interface pulse_tdc_if;
  logic        FIFO_READ;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;

  modport master (output FIFO_READ, input FIFO_EMPTY, input FIFO_DATA);
  modport slave  (input FIFO_READ, output FIFO_EMPTY, output FIFO_DATA);
endinterface

// File: rtl/pulse_tdc_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module pulse_tdc_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         dropped
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indexes match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pulse_tdc.sv
// Pulse-width TDC: measures pulses on TDC_IN in BUS_CLK cycles and queues words.
// Optional PULSE_TDC_TIMESTAMP_EN replaces the event tag with a 16-bit timestamp.
module pulse_tdc
  import pulse_tdc_pkg::*;
#(
  parameter logic [31:0] BASEADDR        = 32'h0000,
  parameter logic [31:0] HIGHADDR        = 32'h000f,
  parameter int          ABUSWIDTH       = 32,
  parameter int          DEPTH           = 8,
  parameter logic [3:0]  DATA_IDENTIFIER = 4'b0100
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [7:0]           BUS_DATA,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic                 TDC_IN,
  pulse_tdc_if.slave           fifo
);

  // ---------------- bus decode ----------------
  logic [ABUSWIDTH-1:0] off;
  logic [3:0]           reg_off;
  logic                 hit, wr_hit, rd_hit;
  logic                 soft_rst, rst_i;

  assign off     = BUS_ADD - ABUSWIDTH'(BASEADDR);
  assign reg_off = off[3:0];
  assign hit     = (off <= ABUSWIDTH'(HIGHADDR - BASEADDR)) && (off[ABUSWIDTH-1:4] == '0);
  assign wr_hit  = BUS_WR & hit;
  assign rd_hit  = BUS_RD & hit;

  // Soft reset lasts exactly one cycle after the write and then clears itself
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) soft_rst <= 1'b0;
    else         soft_rst <= wr_hit && (reg_off == REG_RESET);
  end

  assign rst_i = BUS_RST | soft_rst;

  logic en, invert;

  always_ff @(posedge BUS_CLK or posedge rst_i) begin
    if (rst_i) begin
      en     <= 1'b0;
      invert <= 1'b0;
    end else if (wr_hit && (reg_off == REG_CONF)) begin
      en     <= BUS_DATA[0];
      invert <= BUS_DATA[1];
    end
  end

  // ---------------- input conditioning ----------------
  logic [1:0] sync;
  logic [1:0] settle;
  logic       s, s_prev, armed, rise;

  always_ff @(posedge BUS_CLK or posedge rst_i) begin
    if (rst_i) sync <= 2'b00;
    else       sync <= {sync[0], TDC_IN};
  end

  assign s = sync[1] ^ invert;

  // The synchronizer holds reset zeros for two cycles; S must be seen low on
  // real input data before a rising edge counts, so a pulse already high at
  // reset release is skipped.
  always_ff @(posedge BUS_CLK or posedge rst_i) begin
    if (rst_i) begin
      settle <= 2'b00;
      s_prev <= 1'b0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      s_prev <= s;
      if (settle[1] && !s) armed <= 1'b1;
    end
  end

  assign rise = s & ~s_prev & armed;

  // ---------------- measurement FSM ----------------
  tdc_state_e state, state_nxt;
  logic       start, push;

  always_ff @(posedge BUS_CLK or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise && en) state_nxt = COUNT;
      COUNT:   if (!s)         state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    push  = 1'b0;
    case (state)
      IDLE:    start = rise & en;
      COUNT:   push  = ~s;
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  logic [WIDTH_BITS-1:0] width;
  logic [31:0]           evt_cnt;
  logic [7:0]            lost_cnt;
  logic                  dropped;
  logic [15:0]           tag;

  always_ff @(posedge BUS_CLK or posedge rst_i) begin
    if (rst_i) begin
      width    <= '0;
      evt_cnt  <= '0;
      lost_cnt <= '0;
    end else begin
      if (start)                        width <= WIDTH_BITS'(1);
      else if (state == COUNT && s)     width <= sat_inc(width);
      if (push)                         evt_cnt <= evt_cnt + 1'b1;
      if (dropped && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 1'b1;
    end
  end

`ifdef PULSE_TDC_TIMESTAMP_EN
  logic [15:0] ts_cnt, ts_cap;
  logic [7:0]  ts_hi;

  // Upper byte is frozen on the LSB read so a two-byte read is coherent
  always_ff @(posedge BUS_CLK or posedge rst_i) begin
    if (rst_i) begin
      ts_cnt <= '0;
      ts_cap <= '0;
      ts_hi  <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (start)                          ts_cap <= ts_cnt;
      if (rd_hit && (reg_off == REG_TS))  ts_hi  <= ts_cnt[15:8];
    end
  end

  assign tag = ts_cap;
`else
  assign tag = evt_cnt[15:0];
`endif

  tdc_word_t word;

  always_comb begin
    word.id    = DATA_IDENTIFIER;
    word.tag   = tag;
    word.width = width;
  end

  logic fifo_full;

  pulse_tdc_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (BUS_CLK),
    .rst     (rst_i),
    .push    (push),
    .pop     (fifo.FIFO_READ),
    .din     (word),
    .dout    (fifo.FIFO_DATA),
    .empty   (fifo.FIFO_EMPTY),
    .full    (fifo_full),
    .dropped (dropped)
  );

  // ---------------- bus readback ----------------
  logic [7:0] rd_mux, rd_data;
  logic       rd_oe;

  always_comb begin
    rd_mux = 8'h00;
    case (reg_off)
      REG_RESET:          rd_mux = VERSION;
      REG_CONF:           rd_mux = {6'b0, invert, en};
      REG_EVT:            rd_mux = evt_cnt[7:0];
      REG_EVT + 4'd1:     rd_mux = evt_cnt[15:8];
      REG_EVT + 4'd2:     rd_mux = evt_cnt[23:16];
      REG_EVT + 4'd3:     rd_mux = evt_cnt[31:24];
      REG_LOST:           rd_mux = lost_cnt;
`ifdef PULSE_TDC_TIMESTAMP_EN
      REG_TS:             rd_mux = ts_cnt[7:0];
      REG_TS + 4'd1:      rd_mux = ts_hi;
`endif
      default:            rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge rst_i) begin
    if (rst_i) begin
      rd_oe   <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      rd_oe <= rd_hit;
      if (rd_hit) rd_data <= rd_mux;
    end
  end

  assign BUS_DATA = rd_oe ? rd_data : 8'hzz;

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_pulse_tdc.sv
// Scoreboard bench for pulse_tdc: pulses are modelled as (width, enable) events
// and the expected words are queued; a monitor pops and compares FIFO output.
module tb_pulse_tdc;
  localparam int DEPTH = 8;
`ifdef PULSE_TDC_TIMESTAMP_EN
  localparam logic [31:0] MASK = 32'hF000_0FFF;
`else
  localparam logic [31:0] MASK = 32'hFFFF_FFFF;
`endif

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST = 1'b1;
  logic [31:0] BUS_ADD = '0;
  wire  [7:0]  BUS_DATA;
  logic [7:0]  bus_wdata = '0;
  logic        bus_drv = 1'b0;
  logic        BUS_RD = 1'b0, BUS_WR = 1'b0, TDC_IN = 1'b0;

  pulse_tdc_if fif();

  assign BUS_DATA = bus_drv ? bus_wdata : 8'hzz;

  pulse_tdc #(
    .BASEADDR(32'h0000), .HIGHADDR(32'h000f), .ABUSWIDTH(32),
    .DEPTH(DEPTH), .DATA_IDENTIFIER(4'b0100)
  ) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .BUS_ADD(BUS_ADD), .BUS_DATA(BUS_DATA),
    .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .TDC_IN(TDC_IN), .fifo(fif)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  bit          pop_en = 1'b0;
  bit          m_en = 1'b0, m_inv = 1'b0;
  int unsigned m_evt = 0;
  int          m_lost = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: a measured pulse of n cycles gives min(n,4095) tagged with the
  // number of previously measured pulses; it is lost if 8 words already wait.
  task automatic expect_pulse(input int n);
    logic [31:0] w;
    if (m_en) begin
      w = {4'b0100, m_evt[15:0], (n > 4095) ? 12'hFFF : 12'(n)};
      m_evt++;
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else if (m_lost < 255) m_lost++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_evt = 0; m_lost = 0; m_en = 1'b0; m_inv = 1'b0;
  endtask

  // Monitor: pops and compares whenever the DUT presents a word
  always @(negedge BUS_CLK) begin
    fif.FIFO_READ = 1'b0;
    if (pop_en && !BUS_RST && fif.FIFO_EMPTY === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %h expected none", fif.FIFO_DATA);
      end else begin
        check("fifo_word", fif.FIFO_DATA & MASK, exp_q.pop_front() & MASK);
      end
      fif.FIFO_READ = 1'b1;
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge BUS_CLK);
    BUS_ADD = {28'h0, a}; bus_wdata = d; bus_drv = 1'b1; BUS_WR = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR = 1'b0; bus_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge BUS_CLK);
    BUS_ADD = {28'h0, a}; BUS_RD = 1'b1;
    @(negedge BUS_CLK);
    d = BUS_DATA;
    BUS_RD = 1'b0;
  endtask

  task automatic read_evt(output logic [31:0] e);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(2 + i), b);
      e[8*i +: 8] = b;
    end
  endtask

  task automatic pulse(input int n, input int gap);
    @(negedge BUS_CLK);
    TDC_IN = ~m_inv;
    repeat (n) @(negedge BUS_CLK);
    TDC_IN = m_inv;
    expect_pulse(n);
    repeat (gap) @(negedge BUS_CLK);
  endtask

  task automatic wait_drain();
    pop_en = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge BUS_CLK);
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge BUS_CLK);
    check("drain_empty", 32'(fif.FIFO_EMPTY), 32'd1);
    pop_en = 1'b0;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0]  d;
    logic [31:0] e;
    int          hi;

    repeat (3) @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    @(negedge BUS_CLK);

    // reset state
    check("rst_empty", 32'(fif.FIFO_EMPTY), 32'd1);
    bus_read(4'd0, d); check("version", 32'(d), 32'd1);
    bus_read(4'd1, d); check("conf_rst", 32'(d), 32'd0);
    read_evt(e);       check("evt_rst", e, 32'd0);
    bus_read(4'd6, d); check("lost_rst", 32'(d), 32'd0);
`ifndef PULSE_TDC_TIMESTAMP_EN
    bus_read(4'd7, d); check("ts_absent", 32'(d), 32'd0);
`endif

    // 5-cycle pulse, latency of FIFO_EMPTY
    bus_write(4'd1, 8'h01); m_en = 1'b1;
    @(negedge BUS_CLK); TDC_IN = 1'b1;
    repeat (5) @(negedge BUS_CLK);
    TDC_IN = 1'b0; expect_pulse(5);
    @(negedge BUS_CLK); check("lat_1", 32'(fif.FIFO_EMPTY), 32'd1);
    @(negedge BUS_CLK); check("lat_2", 32'(fif.FIFO_EMPTY), 32'd1);
    @(negedge BUS_CLK); check("lat_3", 32'(fif.FIFO_EMPTY), 32'd0);
`ifndef PULSE_TDC_TIMESTAMP_EN
    check("word_5", fif.FIFO_DATA, 32'h4000_0005);
`endif
    read_evt(e); check("evt_1", e, 32'd1);
    wait_drain();

    // inverted: low pulse of 7 cycles
    bus_write(4'd1, 8'h00); m_en = 1'b0;
    @(negedge BUS_CLK); TDC_IN = 1'b1;
    repeat (4) @(negedge BUS_CLK);
    bus_write(4'd1, 8'h03); m_en = 1'b1; m_inv = 1'b1;
    repeat (3) @(negedge BUS_CLK);
    bus_read(4'd1, d); check("conf_inv", 32'(d), 32'd3);
    pulse(7, 5);
    // back to normal polarity; a pulse while disabled is ignored
    bus_write(4'd1, 8'h00); m_en = 1'b0; m_inv = 1'b0;
    @(negedge BUS_CLK); TDC_IN = 1'b0;
    repeat (4) @(negedge BUS_CLK);
    pulse(6, 5);
    bus_write(4'd1, 8'h01); m_en = 1'b1;
    // EN cleared mid-pulse: pulse of 3+2+4 cycles still recorded
    @(negedge BUS_CLK); TDC_IN = 1'b1;
    repeat (3) @(negedge BUS_CLK);
    bus_write(4'd1, 8'h00);
    repeat (4) @(negedge BUS_CLK);
    TDC_IN = 1'b0; expect_pulse(9); m_en = 1'b0;
    repeat (5) @(negedge BUS_CLK);
    bus_write(4'd1, 8'h01); m_en = 1'b1;
    wait_drain();
    read_evt(e); check("evt_mid", e, m_evt);

    // saturation
    pulse(5000, 5);
    wait_drain();

    // overflow with reads held off
    for (int i = 0; i < 10; i++) pulse($urandom_range(1, 20), $urandom_range(3, 8));
    check("ovf_nonempty", 32'(fif.FIFO_EMPTY), 32'd0);
    bus_read(4'd6, d); check("lost_2", 32'(d), 32'(m_lost));
    read_evt(e); check("evt_ovf", e, m_evt);
    wait_drain();

    // BUS_RST mid-pulse, released while input still high
    @(negedge BUS_CLK); TDC_IN = 1'b1;
    repeat (5) @(negedge BUS_CLK);
    BUS_RST = 1'b1; model_reset();
    repeat (2) @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    bus_write(4'd1, 8'h01); m_en = 1'b1;
    repeat (4) @(negedge BUS_CLK);
    TDC_IN = 1'b0;
    repeat (4) @(negedge BUS_CLK);
    pulse(3, 5);
    check("rst_pulse_ne", 32'(fif.FIFO_EMPTY), 32'd0);
`ifndef PULSE_TDC_TIMESTAMP_EN
    check("word_3", fif.FIFO_DATA, 32'h4000_0003);
`endif
    wait_drain();

    // soft reset with a full FIFO and lost words
    for (int i = 0; i < 10; i++) pulse($urandom_range(1, 10), 4);
    bus_read(4'd6, d); check("lost_pre", 32'(d), 32'(m_lost));
    bus_write(4'd0, 8'hA5); model_reset();
    check("srst_empty", 32'(fif.FIFO_EMPTY), 32'd1);
    bus_read(4'd1, d); check("srst_conf", 32'(d), 32'd0);
    bus_read(4'd6, d); check("srst_lost", 32'(d), 32'd0);
    read_evt(e);       check("srst_evt", e, 32'd0);

    // randomized pulses with occasional enable toggling
    bus_write(4'd1, 8'h01); m_en = 1'b1;
    pop_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        hi = $urandom_range(0, 1);
        bus_write(4'd1, 8'(hi)); m_en = (hi != 0);
      end
      pulse($urandom_range(1, 40), $urandom_range(3, 10));
    end
    wait_drain();
    read_evt(e);       check("evt_rand", e, m_evt);
    bus_read(4'd6, d); check("lost_rand", 32'(d), 32'(m_lost));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_tdc.md
Name: pulse_tdc

Overview:
- Bus-configurable pulse-width time-to-digital converter.
- Fills the empty TDC input slot of the round-robin readout arbiter.
- Measures the width of each pulse on one asynchronous input in BUS_CLK cycles.
- Stores each result as a 32-bit word in an internal FIFO, read by the arbiter through a FIFO_READ/FIFO_EMPTY/FIFO_DATA handshake.

Parameters:
- BASEADDR, 32'h0000, first bus address of the register window.
- HIGHADDR, 32'h000f, last bus address of the register window.
- ABUSWIDTH, 32, width of BUS_ADD.
- DEPTH, 8, internal FIFO depth in 32-bit words; must be a power of two, minimum 2.
- DATA_IDENTIFIER, 4'b0100, value placed in FIFO_DATA[31:28].

Ports:
- BUS_CLK  in  1  single clock for bus, measurement and FIFO.
- BUS_RST  in  1  asynchronous, active-high reset.
- BUS_ADD  in  ABUSWIDTH  bus address.
- BUS_DATA  inout  8  bus data; driven only during a read cycle, Z otherwise.
- BUS_RD  in  1  read strobe.
- BUS_WR  in  1  write strobe.
- TDC_IN  in  1  asynchronous pulse input.
- FIFO_READ  in  1  pop request from the arbiter.
- FIFO_EMPTY  out  1  high when no word is stored.
- FIFO_DATA  out  32  head word, first-word-fall-through.

Behaviour:
- Registers (offsets from BASEADDR):
  - 0 W: any write generates a 1-cycle soft reset, same effect as BUS_RST. Read returns version 8'd1.
  - 1 RW: bit0 EN, bit1 INVERT (measure low pulses), bits 7:2 read 0.
  - 2..5 R: 32-bit event counter, LSB at offset 2.
  - 6 R: LOST_CNT, 8-bit, saturating at 255.
- Bus timing: read data appears on BUS_DATA the cycle after BUS_RD. Addresses outside the window leave BUS_DATA at Z.
- Input conditioning: TDC_IN passes a 2-flop synchronizer (reset value 0), then XOR with INVERT, giving signal S. A rising edge of S is S=1 with the previous S=0.
- State machine:
  - IDLE: on a rising edge of S with EN=1, WIDTH<=1 and go to COUNT.
  - COUNT: while S=1, WIDTH increments, saturating at 12'hFFF. When S=0, push the word and return to IDLE.
  - Clearing EN mid-pulse does not abort; the pulse is completed and recorded.
  - A rising edge of S while EN=0 is ignored for the whole pulse.
- Word format: {DATA_IDENTIFIER, EVT[15:0], WIDTH[11:0]}. EVT is the event counter value before increment. The event counter increments on every push attempt, including dropped words.
- Measured width: a pulse of N BUS_CLK cycles at S yields WIDTH=N (N>=1).
- Latency: the word is visible at FIFO_DATA 1 cycle after the falling edge is detected on S. The input-to-S delay is 2 cycles.
- FIFO full:
  - The push is dropped and LOST_CNT increments (saturating).
  - The FIFO contents are unchanged.
  - Push and pop in the same cycle when full: the pop frees space and the push succeeds.
- FIFO empty: FIFO_READ is ignored, with no underflow and no pointer change.
- FIFO_DATA: holds the head word while FIFO_EMPTY=0. After FIFO_READ, the next word is presented on the following cycle. Value is undefined while empty.
- Reset values (BUS_RST or soft reset): state IDLE, EN=0, INVERT=0, counters 0, LOST_CNT 0, FIFO flushed, FIFO_EMPTY=1, BUS_DATA=Z.
- Reset mid-pulse discards the partial measurement. After reset, a pulse already high is not measured until S returns to 0 and rises again.

Optional Feature:
- Macro: PULSE_TDC_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit timestamp counter (reset 0, wraps at 16'hFFFF).
  - The timestamp is captured at the rising edge of S and replaces EVT in FIFO_DATA[27:12].
  - Offsets 7..8 read the live timestamp, LSB at 7; the upper byte is latched when offset 7 is read.
- Undefined: no timestamp logic; offsets 7..8 read 0.

Decomposition:
- Shared package:
  - Register offset constants (REG_RESET=0, REG_CONF=1, REG_EVT=2, REG_LOST=6, REG_TS=7).
  - WIDTH_BITS=12.
  - State enumeration IDLE/COUNT.
  - VERSION=1.
- One sub-module: pulse_tdc_fifo, a synchronous FWFT FIFO parameterized by DEPTH. It has full/empty flags and simultaneous push/pop support.

Test Plan:
- EN=1, 5-cycle high pulse on TDC_IN -> one word 32'h4000_0005. FIFO_EMPTY goes low 3 cycles after TDC_IN falls; event count reads 1.
- INVERT=1, 7-cycle low pulse -> WIDTH=7, EVT=0. A high pulse produces no word.
- Pulse of 5000 cycles -> WIDTH=12'hFFF (saturated).
- FIFO_READ held 0, 10 pulses with DEPTH=8 -> 8 words stored, LOST_CNT=2, event count=10. Popping yields EVT 0..7 in order.
- BUS_RST asserted mid-pulse and released while TDC_IN is still high -> no word for that pulse. The next full pulse of 3 cycles yields 32'h4000_0003.
- Write register 0 with 4 words stored -> FIFO_EMPTY=1, EN=0, register 6 reads 0, event count reads 0.
